// File: rtl/ex_muldiv_unit.sv
// Multi-cycle multiply/divide engine beside the EX stage, writing HI/LO on completion.
// Radix-2 shift-add multiply and restoring shift-subtract divide over WIDTH iterations.
// Optional feature macro: MULDIV_FAST_MUL_EN selects a single-cycle multiplier for
// MULT/MULTU; divide stays iterative either way.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cancel,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic             stall_req,
  output logic             busy,
  output logic             hilo_write_en,
  output logic [WIDTH-1:0] hi_write_data,
  output logic [WIDTH-1:0] lo_write_data
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;      // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
  logic [WIDTH-1:0]   opb_q;      // multiplicand or divisor magnitude
  logic               is_div_q, neg_res_q, neg_rem_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  // Operand decode at start: op[0] set means unsigned.
  logic             is_signed, sign_1, sign_2, div_zero, fast_mul, accept, last_iter;
  logic [WIDTH-1:0] mag_1, mag_2;

  assign is_signed = ~op[0];
  assign sign_1    = is_signed & operand_1[WIDTH-1];
  assign sign_2    = is_signed & operand_2[WIDTH-1];
  assign mag_1     = sign_1 ? -operand_1 : operand_1;
  assign mag_2     = sign_2 ? -operand_2 : operand_2;
  assign div_zero  = op[1] && (operand_2 == '0);
  assign accept    = start && !cancel;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  // Sign-extend to 2*WIDTH; the low 2*WIDTH bits of the product are then exact.
  assign fast_prod = {{WIDTH{sign_1}}, operand_1} * {{WIDTH{sign_2}}, operand_2};
  assign fast_mul  = !op[1];
`else
  assign fast_mul  = 1'b0;
`endif

  // One radix-2 iteration of either algorithm.
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               no_borrow;
  logic [2*WIDTH-1:0] mul_next, div_next, step_next, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opb_q};
    no_borrow = ~div_diff[WIDTH];
    div_next  = {(no_borrow ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], no_borrow};
    step_next = is_div_q ? div_next : mul_next;
    prod_fix  = neg_res_q ? -step_next : step_next;
    quo_fix   = neg_res_q ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
    rem_fix   = neg_rem_q ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
  end

  // Next-state logic; cancel outranks both start and completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = (div_zero || fast_mul) ? StDone : StCalc;
      StCalc: begin
        if (cancel)         state_d = StIdle;
        else if (last_iter) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Datapath: latch operands at start, iterate in CALC, register results on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            cnt_q     <= '0;
            acc_q     <= {{WIDTH{1'b0}}, mag_1};
            opb_q     <= mag_2;
            is_div_q  <= op[1];
            neg_res_q <= sign_1 ^ sign_2;
            neg_rem_q <= op[1] & sign_1;
            if (div_zero) begin
              hi_q <= operand_1;
              lo_q <= '1;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (fast_mul) begin
              hi_q <= fast_prod[2*WIDTH-1:WIDTH];
              lo_q <= fast_prod[WIDTH-1:0];
            end
`endif
          end
        end
        StCalc: begin
          if (!cancel) begin
            acc_q <= step_next;
            cnt_q <= cnt_q + 1'b1;
            if (last_iter) begin
              hi_q <= is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_req     = ((state_q == StIdle) && start) || (state_q == StCalc);
  assign busy          = (state_q == StCalc) || (state_q == StDone);
  assign hilo_write_en = (state_q == StDone);
  assign hi_write_data = hi_q;
  assign lo_write_data = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (WIDTH=32).
module tb_ex_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic         clk = 1'b0;
  logic         rst, start, cancel;
  logic [1:0]   op;
  logic [W-1:0] operand_1, operand_2;
  logic         stall_req, busy, hilo_write_en;
  logic [W-1:0] hi_write_data, lo_write_data;

  int errors = 0;
  int checks = 0;

  ex_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cancel        (cancel),
    .op            (op),
    .operand_1     (operand_1),
    .operand_2     (operand_2),
    .stall_req     (stall_req),
    .busy          (busy),
    .hilo_write_en (hilo_write_en),
    .hi_write_data (hi_write_data),
    .lo_write_data (lo_write_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op, measure strobe latency (1 = strobe visible right after the start edge).
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_lat,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; operand_1 = a; operand_2 = b;
    #1 check_eq({tag, " stall on start"}, 64'(stall_req), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!hilo_write_en && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, " hi"}, 64'(hi_write_data), 64'(exp_hi));
    check_eq({tag, " lo"}, 64'(lo_write_data), 64'(exp_lo));
    check_eq({tag, " stall in done"}, 64'(stall_req), 64'd0);
    check_eq({tag, " busy in done"}, 64'(busy), 64'd1);
    @(posedge clk); #1;
    check_eq({tag, " strobe one cycle"}, 64'(hilo_write_en), 64'd0);
    check_eq({tag, " idle after done"}, 64'(busy), 64'd0);
    check_eq({tag, " hi held"}, 64'(hi_write_data), 64'(exp_hi));
  endtask

  task automatic count_strobes(input string tag, input int n);
    int strobes = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (hilo_write_en) strobes++;
    end
    check_eq(tag, 64'(strobes), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00;
    operand_1 = '0; operand_2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset stall", 64'(stall_req), 64'd0);
    check_eq("reset busy", 64'(busy), 64'd0);
    check_eq("reset strobe", 64'(hilo_write_en), 64'd0);
    check_eq("reset hi", 64'(hi_write_data), 64'd0);
    check_eq("reset lo", 64'(lo_write_data), 64'd0);
    rst = 1'b0;

    run_op("MULT -1*2",   2'b00, 32'hFFFF_FFFF, 32'h2, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("MULTU max*2", 2'b01, 32'hFFFF_FFFF, 32'h2, MUL_LAT, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("DIV -7/2",    2'b10, 32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("DIVU 100/7",  2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    run_op("DIVU 5/0",    2'b11, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF);
    run_op("DIV min/-1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);

    // Cancel a DIVU at cycle 10.
    @(negedge clk);
    start = 1'b1; op = 2'b11; operand_1 = 32'd1000; operand_2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 check_eq("cancel busy before", 64'(busy), 64'd1);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check_eq("cancel busy after", 64'(busy), 64'd0);
    check_eq("cancel no strobe", 64'(hilo_write_en), 64'd0);
    check_eq("cancel stall idle", 64'(stall_req), 64'd0);
    count_strobes("cancel strobes later", 40);
    run_op("MULTU 3*4", 2'b01, 32'd3, 32'd4, MUL_LAT, 32'd0, 32'd12);

    // Reset mid-operation, with an ignored start while busy.
    @(negedge clk);
    start = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
    op = 2'b11; operand_1 = 32'd9; operand_2 = 32'd2;
`else
    op = 2'b00; operand_1 = 32'hFFFF_FFFF; operand_2 = 32'h2;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 2'b11; operand_1 = 32'd5; operand_2 = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy start ignored busy", 64'(busy), 64'd1);
    check_eq("busy start ignored strobe", 64'(hilo_write_en), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midop reset busy", 64'(busy), 64'd0);
    check_eq("midop reset stall", 64'(stall_req), 64'd0);
    check_eq("midop reset hi", 64'(hi_write_data), 64'd0);
    check_eq("midop reset lo", 64'(lo_write_data), 64'd0);
    count_strobes("midop reset strobes", 40);
    check_eq("idle stall", 64'(stall_req), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
